// File: rtl/ifetch_prefetch.sv
// Prefetching instruction fetch unit: word requests to instruction memory, a small
// prefetch FIFO, and halfword realignment into 16-bit (C) or 32-bit instructions.
module ifetch_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0100,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is_c
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ifetch_prefetch: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (MAX_OUTST < 1) begin : g_bad_outst
    $error("ifetch_prefetch: MAX_OUTST must be at least 1");
  end

  logic [31:0]   fetch_addr;
  logic [31:0]   pc;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;

  logic [31:0] h0;
  logic [15:0] h1_lo;
  logic [15:0] half;
  logic        is_c;
  logic        need_two;
  logic        fire, pop, push, drop, req_fire;
  logic [31:0] occupancy;
  logic        unused_bits;

  assign unused_bits = redirect_pc[0];

  always_comb begin
    rd_nxt   = rd_ptr + 1'b1;
    h0       = fifo_mem[rd_ptr];
    h1_lo    = fifo_mem[rd_nxt][15:0];
    half     = pc[1] ? h0[31:16] : h0[15:0];
    is_c     = (half[1:0] != 2'b11);
    need_two = pc[1] & ~is_c;
    instr_valid = need_two ? (fifo_count >= CW'(2)) : (fifo_count != '0);

    instr      = '0;
    instr_pc   = '0;
    instr_is_c = 1'b0;
    if (instr_valid) begin
      instr_pc   = pc;
      instr_is_c = is_c;
      if (is_c)       instr = {16'b0, half};
      else if (pc[1]) instr = {h1_lo, h0[31:16]};
      else            instr = h0;
    end
  end

  // Reservation: in-flight requests count against FIFO space so responses can't overflow it.
  always_comb begin
    occupancy     = 32'(fifo_count) + 32'(outstanding);
    mem_req_valid = ~reset & ~redirect & (discard == '0)
                  & (32'(outstanding) < 32'(MAX_OUTST))
                  & (occupancy < 32'(FIFO_DEPTH));
    mem_req_addr  = fetch_addr;
    req_fire      = mem_req_valid & mem_req_ready;
    drop          = mem_resp_valid & (discard != '0);
    push          = mem_resp_valid & (discard == '0);
    fire          = instr_valid & instr_ready & ~redirect;
    pop           = fire & (pc[1] | ~is_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr  <= {RESET_PC[31:2], 2'b00};
      pc          <= {RESET_PC[31:1], 1'b0};
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      // Whatever is still in flight (less a response landing now) must be dropped on return.
      fetch_addr  <= {redirect_pc[31:2], 2'b00};
      pc          <= {redirect_pc[31:1], 1'b0};
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= discard + outstanding - OW'(mem_resp_valid);
    end else begin
      if (req_fire) fetch_addr <= fetch_addr + 32'd4;
      outstanding <= outstanding + OW'(req_fire) - OW'(push);
      if (drop) discard <= discard - 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (fire) pc <= pc + (is_c ? 32'd2 : 32'd4);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !redirect && push) fifo_mem[wr_ptr] <= mem_resp_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && !redirect && push && !pop) assert (fifo_count < CW'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: an in-order memory model with configurable
// latency and ready pacing, a delivery monitor, and hand-computed expectations.
module tb_ifetch_prefetch;

  logic        clk, reset, redirect;
  logic [31:0] redirect_pc;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        instr_is_c;

  ifetch_prefetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4), .MAX_OUTST(4)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_is_c(instr_is_c)
  );

  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins; logic c; int cyc;} dlv_t;

  logic [31:0] mem [logic [31:0]];
  pend_t       pend[$];
  dlv_t        dq[$];
  logic [31:0] req_log[$];
  int          cyc = 0;
  int          lat = 1;
  int          ready_period = 1;
  int          resp_cyc_104 = -1;
  int          tests = 0;
  int          fails = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Unwritten words default to distinct 32-bit encodings (low bits 2'b11).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[24:0], 7'h13};
  endfunction

  // Memory model: acts just after each falling edge, for the cycle that ends at the next rising edge.
  initial begin
    pend_t r;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (reset) begin
        pend.delete();
        mem_resp_valid = 0;
        mem_req_ready  = 0;
      end else begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          r = pend.pop_front();
          mem_resp_valid = 1;
          mem_resp_data  = mem_word(r.addr);
          if (r.addr == 32'h104) resp_cyc_104 = cyc;
        end else begin
          mem_resp_valid = 0;
        end
        mem_req_ready = ((cyc % ready_period) == 0);
        if (mem_req_valid && mem_req_ready) begin
          pend.push_back('{addr: mem_req_addr, due: cyc + lat});
          req_log.push_back(mem_req_addr);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk); #2;
      if (!reset && !redirect && instr_valid && instr_ready)
        dq.push_back('{pc: instr_pc, ins: instr, c: instr_is_c, cyc: cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_dlv(input int n, input string tag);
    int k = 0;
    while (dq.size() < n && k < 200) begin
      @(negedge clk); #3;
      k++;
    end
    tests++;
    assert (dq.size() >= n) else begin
      fails++;
      $error("FAIL %s timeout: observed %0d deliveries, expected %0d", tag, dq.size(), n);
    end
  endtask

  task automatic begin_test(input int l, input int p);
    @(negedge clk);
    reset = 1; redirect = 0; instr_ready = 1;
    lat = l; ready_period = p;
    step(2);
    mem.delete(); dq.delete(); req_log.delete();
    resp_cyc_104 = -1;
  endtask

  initial begin
    reset = 1; redirect = 0; redirect_pc = 0; instr_ready = 1;

    // Reset state
    step(3); #3;
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_instr_is_c", 32'(instr_is_c), 0);

    // Straight-line 32-bit stream, zero-wait memory
    begin_test(1, 1);
    reset = 0;
    wait_dlv(4, "line_wait");
    chk("line_req0", req_log[0], 32'h100);
    chk("line_req1", req_log[1], 32'h104);
    for (int i = 0; i < 4; i++) begin
      chk("line_pc", dq[i].pc, 32'h100 + 32'(4 * i));
      chk("line_instr", dq[i].ins, mem_word(32'h100 + 32'(4 * i)));
      chk("line_is_c", 32'(dq[i].c), 0);
      chk("line_cycle", 32'(dq[i].cyc), 32'(dq[0].cyc + i));
    end

    // Two compressed halves then a 32-bit word
    begin_test(1, 1);
    mem[32'h100] = 32'h0001_4501;
    mem[32'h104] = 32'h0000_0513;
    reset = 0;
    wait_dlv(3, "c_wait");
    chk("c0_pc", dq[0].pc, 32'h100);   chk("c0_instr", dq[0].ins, 32'h0000_4501); chk("c0_is_c", 32'(dq[0].c), 1);
    chk("c1_pc", dq[1].pc, 32'h102);   chk("c1_instr", dq[1].ins, 32'h0000_0001); chk("c1_is_c", 32'(dq[1].c), 1);
    chk("c2_pc", dq[2].pc, 32'h104);   chk("c2_instr", dq[2].ins, 32'h0000_0513); chk("c2_is_c", 32'(dq[2].c), 0);

    // 32-bit instruction straddling two words, memory paced to one request per 4 cycles
    begin_test(1, 4);
    mem[32'h100] = 32'h0093_4501;
    mem[32'h104] = 32'h4501_00A0;
    reset = 0;
    wait_dlv(2, "straddle_wait");
    chk("straddle_c_pc", dq[0].pc, 32'h100);
    chk("straddle_pc", dq[1].pc, 32'h102);
    chk("straddle_instr", dq[1].ins, 32'h00A0_0093);
    chk("straddle_is_c", 32'(dq[1].c), 0);
    chk("straddle_timing", 32'(dq[1].cyc), 32'(resp_cyc_104 + 1));

    // Decode stall for 10 cycles: reservation limits requests to the FIFO depth
    begin_test(1, 1);
    instr_ready = 0;
    reset = 0;
    step(2); #3;
    chk("stall_valid_early", 32'(instr_valid), 1);
    chk("stall_pc_early", instr_pc, 32'h100);
    chk("stall_instr_early", instr, mem_word(32'h100));
    @(negedge clk);
    step(7); #3;
    chk("stall_req_count", 32'(req_log.size()), 4);
    chk("stall_valid_late", 32'(instr_valid), 1);
    chk("stall_pc_late", instr_pc, 32'h100);
    chk("stall_instr_late", instr, mem_word(32'h100));
    @(negedge clk);
    instr_ready = 1;
    wait_dlv(8, "stall_resume_wait");
    for (int i = 0; i < 8; i++) begin
      chk("stall_resume_pc", dq[i].pc, 32'h100 + 32'(4 * i));
      chk("stall_resume_instr", dq[i].ins, mem_word(32'h100 + 32'(4 * i)));
    end

    // Redirect with three requests in flight (5-cycle latency); bit0 of target ignored
    begin_test(5, 1);
    mem[32'h200] = 32'h0001_4501;
    reset = 0;
    step(3);
    redirect = 1; redirect_pc = 32'h0000_0203;
    #3;
    chk("redir_req_valid", 32'(mem_req_valid), 0);
    chk("redir_outstanding_reqs", 32'(req_log.size()), 3);
    @(negedge clk);
    redirect = 0;
    #3;
    chk("redir_valid_n1", 32'(instr_valid), 0);
    wait_dlv(2, "redir_wait");
    chk("redir_next_addr", req_log[3], 32'h200);
    chk("redir_pc0", dq[0].pc, 32'h202);
    chk("redir_instr0", dq[0].ins, 32'h0000_0001);
    chk("redir_is_c0", 32'(dq[0].c), 1);
    chk("redir_pc1", dq[1].pc, 32'h204);
    chk("redir_instr1", dq[1].ins, mem_word(32'h204));

    // Reset mid-stream
    begin_test(1, 1);
    reset = 0;
    step(6);
    reset = 1;
    step(1); #3;
    chk("midrst_instr_valid", 32'(instr_valid), 0);
    chk("midrst_req_valid", 32'(mem_req_valid), 0);
    @(negedge clk);
    dq.delete(); req_log.delete();
    reset = 0;
    wait_dlv(2, "midrst_wait");
    chk("midrst_req0", req_log[0], 32'h100);
    chk("midrst_pc0", dq[0].pc, 32'h100);
    chk("midrst_pc1", dq[1].pc, 32'h104);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
